m68k_bus_arbiter: RTL and testbench
===================================

M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of PI_CLK flops synchronising each asynchronous input (minimum 2).
REQ-002 SHALL have parameter BG_TIMEOUT, default 16, number of M68K_CLK falling edges BG_n may stay low without BGACK_n before withdrawal.
REQ-003 SHALL have port PI_CLK  in  1  sole clock (200 MHz); all state changes on its rising edge.
REQ-004 SHALL have port RST_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port M68K_CLK  in  1  7 MHz bus clock; sampled as data, never used as a clock.
REQ-006 SHALL have port M68K_BR_n  in  1  external bus request, asynchronous.
REQ-007 SHALL have port M68K_BGACK_n  in  1  external bus grant acknowledge, asynchronous.
REQ-008 SHALL have port M68K_AS_IN_n  in  1  sampled bus address strobe, asynchronous.
REQ-009 SHALL have port LOCAL_REQ  in  1  bus cycle engine request level, synchronous to PI_CLK.
REQ-010 SHALL have port LOCAL_DONE  in  1  one-PI_CLK pulse at end of local cycle (S7).
REQ-011 SHALL have port LOCAL_GNT  out  1  permission for bus cycle engine to start/hold its cycle.
REQ-012 SHALL have port M68K_BG_n  out  1  bus grant to external master.
REQ-013 SHALL have port BUS_DRIVE_EN  out  1  high = our AS/DS/RW/FC/address drivers enabled.
REQ-014 SHALL have port EXT_OWNER  out  1  high while external master holds the bus (BGACK asserted).
REQ-015 SHALL have port ARB_STATE  out  3  current state encoding, for Pi status register.

Function
REQ-016 SHALL synchronise BR_n, BGACK_n, AS_IN_n, M68K_CLK through SYNC_STAGES flops; c7m_fall = previous-sync 1, current-sync 0.
REQ-017 SHALL implement states IDLE=0, LOCAL=1, PEND=2, GRANTED=3, EXT=4, RELEASE=5; codes 6/7 SHALL recover to IDLE next cycle.
REQ-018 IDLE: LOCAL_REQ=1 and (sync BR_n=1 or fair=1) -> LOCAL, LOCAL_GNT=1 next cycle.
REQ-019 IDLE: sync BR_n=0 and not fair-with-LOCAL_REQ -> PEND; BR wins when both first seen same cycle and fair=0.
REQ-020 LOCAL: LOCAL_GNT held until LOCAL_DONE; on LOCAL_DONE LOCAL_GNT=0 and -> PEND if sync BR_n=0, else IDLE; BR arriving mid-cycle never aborts the local cycle.
REQ-021 PEND: on c7m_fall with sync AS_IN_n=1 -> GRANTED, M68K_BG_n=0, BUS_DRIVE_EN=0, BG counter cleared; LOCAL_REQ ignored.
REQ-022 PEND: sync BR_n returning high before grant -> IDLE, BG_n never asserted.
REQ-023 GRANTED: sync BGACK_n=0 -> EXT next cycle, M68K_BG_n=1, EXT_OWNER=1.
REQ-024 GRANTED: sync BR_n=1 with BGACK_n=1 on c7m_fall, or BG counter reaching BG_TIMEOUT -> IDLE, BG_n=1, BUS_DRIVE_EN=1.
REQ-025 BG counter SHALL increment once per c7m_fall in GRANTED only, saturating at BG_TIMEOUT.
REQ-026 EXT: BUS_DRIVE_EN=0 held; sync BGACK_n=1 -> RELEASE, EXT_OWNER=0.
REQ-027 RELEASE: on next c7m_fall -> IDLE, BUS_DRIVE_EN=1, fair=1 (BGACK re-asserted meanwhile -> back to EXT).
REQ-028 fair SHALL clear when LOCAL_GNT asserts, or in IDLE when LOCAL_REQ=0; guarantees one local cycle between back-to-back external tenures.
REQ-029 LOCAL_GNT and BUS_DRIVE_EN=0 SHALL never be high together; BG_n=0 SHALL never coincide with LOCAL_GNT=1.
REQ-030 All outputs SHALL be registered; ARB_STATE equals state register.

Reset
REQ-031 RST_n=0 SHALL immediately force state IDLE, M68K_BG_n=1, LOCAL_GNT=0, BUS_DRIVE_EN=1, EXT_OWNER=0, fair=0, BG counter 0, sync flops to inactive (_n=1, clock=0).
REQ-032 Reset mid-grant or mid-EXT SHALL release BG_n without waiting for BGACK; after release arbitration restarts from IDLE.

Verification
REQ-033 LOCAL_REQ=1, BR_n=1 -> LOCAL_GNT=1 within 2 PI_CLK; LOCAL_DONE -> LOCAL_GNT=0, ARB_STATE=0.
REQ-034 BR_n=0 during local cycle -> LOCAL_GNT held until LOCAL_DONE, then BG_n=0 at first c7m_fall with AS_IN_n=1; BGACK_n=0 -> BG_n=1, EXT_OWNER=1, ARB_STATE=4.
REQ-035 BR_n=0, BG_n=0, no BGACK for 16 c7m falls -> BG_n=1, BUS_DRIVE_EN=1, ARB_STATE=0.
REQ-036 BGACK_n released while LOCAL_REQ=1 and BR_n=0 -> after RELEASE LOCAL_GNT=1 before next BG_n=0 (fairness).
REQ-037 RST_n=0 during EXT -> BG_n=1, BUS_DRIVE_EN=1, EXT_OWNER=0 asynchronously; simultaneous BR_n=0 and LOCAL_REQ=1 from IDLE with fair=0 -> PEND, LOCAL_GNT stays 0.

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : m68k_bus_arbiter
// Description : Bus arbiter between a local bus cycle engine and an external
//               68000-style bus master (BR/BG/BGACK handshake).
//               Runs entirely in the PI_CLK domain; the 7 MHz M68K_CLK and
//               the external handshake lines are synchronised and treated as
//               data.
// Ports       :
//   PI_CLK        in   sole clock, all state changes on its rising edge
//   RST_n         in   asynchronous active-low reset
//   M68K_CLK      in   bus clock, sampled as data (falling edge detected)
//   M68K_BR_n     in   external bus request (async)
//   M68K_BGACK_n  in   external bus grant acknowledge (async)
//   M68K_AS_IN_n  in   sampled bus address strobe (async)
//   LOCAL_REQ     in   local engine request level (PI_CLK domain)
//   LOCAL_DONE    in   one-cycle pulse at end of local bus cycle
//   LOCAL_GNT     out  local engine may start / hold its cycle
//   M68K_BG_n     out  bus grant to the external master
//   BUS_DRIVE_EN  out  high = our AS/DS/RW/FC/address drivers enabled
//   EXT_OWNER     out  high while the external master owns the bus
//   ARB_STATE     out  current arbiter state code
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_bus_arbiter #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, must be >= 2
    parameter int BG_TIMEOUT  = 16   // M68K_CLK falls allowed without BGACK
) (
    input  logic       PI_CLK,
    input  logic       RST_n,
    input  logic       M68K_CLK,
    input  logic       M68K_BR_n,
    input  logic       M68K_BGACK_n,
    input  logic       M68K_AS_IN_n,
    input  logic       LOCAL_REQ,
    input  logic       LOCAL_DONE,
    output logic       LOCAL_GNT,
    output logic       M68K_BG_n,
    output logic       BUS_DRIVE_EN,
    output logic       EXT_OWNER,
    output logic [2:0] ARB_STATE
);

    // ------------------------------------------------------------------------
    // Constants and state encoding
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(BG_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(BG_TIMEOUT);

    // Synchroniser bit order: {BR_n, BGACK_n, AS_IN_n, M68K_CLK}.
    // Reset value leaves the active-low lines inactive and the clock low.
    localparam logic [3:0] c_SYNC_RST = 4'b1110;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOCAL   = 3'd1,
        S_PEND    = 3'd2,
        S_GRANTED = 3'd3,
        S_EXT     = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic                        r_c7m_prev;
    logic [3:0]                  w_async;
    logic [3:0]                  w_sync;
    logic                        w_br_s;
    logic                        w_bgack_s;
    logic                        w_as_s;
    logic                        w_c7m_s;
    logic                        w_c7m_fall;

    assign w_async = {M68K_BR_n, M68K_BGACK_n, M68K_AS_IN_n, M68K_CLK};

    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync     <= {SYNC_STAGES{c_SYNC_RST}};
            r_c7m_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], w_async};
            r_c7m_prev <= w_c7m_s;
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_br_s     = w_sync[3];
    assign w_bgack_s  = w_sync[2];
    assign w_as_s     = w_sync[1];
    assign w_c7m_s    = w_sync[0];
    // Falling edge of the bus clock as seen after synchronisation
    assign w_c7m_fall = r_c7m_prev & ~w_c7m_s;

    // ------------------------------------------------------------------------
    // Arbiter state machine with registered outputs
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic                 r_gnt;
    logic                 r_bg_n;
    logic                 r_drive;
    logic                 r_ext;
    // Set when an external tenure ends; forces the next arbitration in IDLE
    // to favour a waiting local request so back-to-back external tenures
    // cannot starve the local engine.
    logic                 r_fair;
    logic [c_CNT_W-1:0]   r_bg_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;

    // Saturating increment of the grant-without-acknowledge counter
    assign w_cnt_next = (r_bg_cnt == c_TIMEOUT) ? r_bg_cnt : r_bg_cnt + 1'b1;

    always_ff @(posedge PI_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state  <= S_IDLE;
            r_gnt    <= 1'b0;
            r_bg_n   <= 1'b1;
            r_drive  <= 1'b1;
            r_ext    <= 1'b0;
            r_fair   <= 1'b0;
            r_bg_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_gnt  <= 1'b0;
                    r_bg_n <= 1'b1;
                    r_drive <= 1'b1;
                    r_ext  <= 1'b0;
                    if (!LOCAL_REQ) begin
                        r_fair <= 1'b0;
                    end
                    // Local wins only if no synchronised BR is pending, or
                    // if the previous owner was external (fairness). On a
                    // tie with fair clear the external request wins.
                    if (LOCAL_REQ && (w_br_s || r_fair)) begin
                        r_state <= S_LOCAL;
                        r_gnt   <= 1'b1;
                        r_fair  <= 1'b0;
                    end else if (!w_br_s) begin
                        r_state <= S_PEND;
                    end
                end

                S_LOCAL: begin
                    // A local cycle always runs to completion; a BR that
                    // arrives meanwhile is serviced afterwards.
                    if (LOCAL_DONE) begin
                        r_gnt   <= 1'b0;
                        r_state <= w_br_s ? S_IDLE : S_PEND;
                    end
                end

                S_PEND: begin
                    if (w_br_s) begin
                        // Request withdrawn before grant was issued
                        r_state <= S_IDLE;
                    end else if (w_c7m_fall && w_as_s) begin
                        // Grant only on a bus clock fall with the bus idle
                        r_state  <= S_GRANTED;
                        r_bg_n   <= 1'b0;
                        r_drive  <= 1'b0;
                        r_bg_cnt <= '0;
                    end
                end

                S_GRANTED: begin
                    if (!w_bgack_s) begin
                        r_state <= S_EXT;
                        r_bg_n  <= 1'b1;
                        r_ext   <= 1'b1;
                    end else if (w_c7m_fall) begin
                        r_bg_cnt <= w_cnt_next;
                        if (w_br_s || (w_cnt_next == c_TIMEOUT)) begin
                            // Requester gave up or never acknowledged
                            r_state <= S_IDLE;
                            r_bg_n  <= 1'b1;
                            r_drive <= 1'b1;
                        end
                    end
                end

                S_EXT: begin
                    r_drive <= 1'b0;
                    if (w_bgack_s) begin
                        r_state <= S_RELEASE;
                        r_ext   <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    if (!w_bgack_s) begin
                        // External master re-acknowledged before handover
                        r_state <= S_EXT;
                        r_ext   <= 1'b1;
                    end else if (w_c7m_fall) begin
                        r_state <= S_IDLE;
                        r_drive <= 1'b1;
                        r_fair  <= 1'b1;
                    end
                end

                default: begin
                    // Unused codes recover to a safe idle bus
                    r_state <= S_IDLE;
                    r_gnt   <= 1'b0;
                    r_bg_n  <= 1'b1;
                    r_drive <= 1'b1;
                    r_ext   <= 1'b0;
                end
            endcase
        end
    end

    assign LOCAL_GNT    = r_gnt;
    assign M68K_BG_n    = r_bg_n;
    assign BUS_DRIVE_EN = r_drive;
    assign EXT_OWNER    = r_ext;
    assign ARB_STATE    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_m68k_bus_arbiter
// Description : Directed self-checking bench for m68k_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_arbiter;

    logic       PI_CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       M68K_CLK = 1'b0;
    logic       M68K_BR_n = 1'b1;
    logic       M68K_BGACK_n = 1'b1;
    logic       M68K_AS_IN_n = 1'b1;
    logic       LOCAL_REQ = 1'b0;
    logic       LOCAL_DONE = 1'b0;
    logic       LOCAL_GNT;
    logic       M68K_BG_n;
    logic       BUS_DRIVE_EN;
    logic       EXT_OWNER;
    logic [2:0] ARB_STATE;

    int errors = 0;
    int checks = 0;

    m68k_bus_arbiter #(
        .SYNC_STAGES (2),
        .BG_TIMEOUT  (16)
    ) u_dut (
        .PI_CLK       (PI_CLK),
        .RST_n        (RST_n),
        .M68K_CLK     (M68K_CLK),
        .M68K_BR_n    (M68K_BR_n),
        .M68K_BGACK_n (M68K_BGACK_n),
        .M68K_AS_IN_n (M68K_AS_IN_n),
        .LOCAL_REQ    (LOCAL_REQ),
        .LOCAL_DONE   (LOCAL_DONE),
        .LOCAL_GNT    (LOCAL_GNT),
        .M68K_BG_n    (M68K_BG_n),
        .BUS_DRIVE_EN (BUS_DRIVE_EN),
        .EXT_OWNER    (EXT_OWNER),
        .ARB_STATE    (ARB_STATE)
    );

    // PI_CLK 10 ns; M68K_CLK 140 ns, offset so its edges never meet PI_CLK's
    always #5 PI_CLK = ~PI_CLK;
    initial begin
        #3;
        forever #70 M68K_CLK = ~M68K_CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Safety invariants checked every cycle outside reset
    always @(negedge PI_CLK) begin
        if (RST_n) begin
            checks++;
            if ((LOCAL_GNT && !BUS_DRIVE_EN) || (LOCAL_GNT && !M68K_BG_n)) begin
                errors++;
                $display("FAIL invariant: GNT=%b DRIVE=%b BG_n=%b at %0t",
                         LOCAL_GNT, BUS_DRIVE_EN, M68K_BG_n, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge PI_CLK);
    endtask

    task automatic do_reset();
        M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1; M68K_AS_IN_n = 1'b1;
        LOCAL_REQ = 1'b0; LOCAL_DONE = 1'b0;
        RST_n = 1'b0;
        tick(2);
        RST_n = 1'b1;
        tick(4);
    endtask

    // Wait for BG_n low (bounded), report if it never came
    task automatic wait_grant(input string name);
        int n = 0;
        while (M68K_BG_n !== 1'b0 && n < 60) begin tick(1); n++; end
        checks++;
        if (M68K_BG_n !== 1'b0) begin
            errors++;
            $display("FAIL %s: BG_n=%b required 0 within 60 cycles", name, M68K_BG_n);
        end
    endtask

    task automatic wait_state(input string name, input logic [2:0] st);
        int n = 0;
        while (ARB_STATE !== st && n < 60) begin tick(1); n++; end
        checks++;
        if (ARB_STATE !== st) begin
            errors++;
            $display("FAIL %s: ARB_STATE=%0d required %0d within 60 cycles", name, ARB_STATE, st);
        end
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        tick(2);
        checks++; if (M68K_BG_n !== 1'b1) begin errors++; $display("FAIL reset_bg: got %b want 1", M68K_BG_n); end
        checks++; if (LOCAL_GNT !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", LOCAL_GNT); end
        checks++; if (BUS_DRIVE_EN !== 1'b1) begin errors++; $display("FAIL reset_drive: got %b want 1", BUS_DRIVE_EN); end
        checks++; if (EXT_OWNER !== 1'b0) begin errors++; $display("FAIL reset_ext: got %b want 0", EXT_OWNER); end
        checks++; if (ARB_STATE !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", ARB_STATE); end
        RST_n = 1'b1;
        tick(4);
        checks++; if (ARB_STATE !== 3'd0) begin errors++; $display("FAIL reset_idle_after: got %0d want 0", ARB_STATE); end
    endtask

    task automatic test_local();
        LOCAL_REQ = 1'b1;
        tick(1);
        checks++; if (LOCAL_GNT !== 1'b1) begin errors++; $display("FAIL local_gnt: got %b want 1", LOCAL_GNT); end
        checks++; if (ARB_STATE !== 3'd1) begin errors++; $display("FAIL local_state: got %0d want 1", ARB_STATE); end
        tick(4);
        checks++; if (LOCAL_GNT !== 1'b1) begin errors++; $display("FAIL local_hold: got %b want 1", LOCAL_GNT); end
        LOCAL_DONE = 1'b1; LOCAL_REQ = 1'b0;
        tick(1);
        LOCAL_DONE = 1'b0;
        checks++; if (LOCAL_GNT !== 1'b0) begin errors++; $display("FAIL local_done_gnt: got %b want 0", LOCAL_GNT); end
        checks++; if (ARB_STATE !== 3'd0) begin errors++; $display("FAIL local_done_state: got %0d want 0", ARB_STATE); end
        tick(3);
    endtask

    task automatic test_br_during_local();
        LOCAL_REQ = 1'b1;
        tick(1);
        M68K_BR_n = 1'b0;
        tick(10);
        checks++; if (LOCAL_GNT !== 1'b1 || ARB_STATE !== 3'd1) begin
            errors++; $display("FAIL br_mid_local: gnt=%b state=%0d want 1/1", LOCAL_GNT, ARB_STATE);
        end
        checks++; if (M68K_BG_n !== 1'b1) begin errors++; $display("FAIL br_mid_local_bg: got %b want 1", M68K_BG_n); end
        LOCAL_DONE = 1'b1; LOCAL_REQ = 1'b0;
        tick(1);
        LOCAL_DONE = 1'b0;
        checks++; if (ARB_STATE !== 3'd2 || LOCAL_GNT !== 1'b0) begin
            errors++; $display("FAIL br_after_done: state=%0d gnt=%b want 2/0", ARB_STATE, LOCAL_GNT);
        end
        wait_grant("br_grant");
        checks++; if (ARB_STATE !== 3'd3 || BUS_DRIVE_EN !== 1'b0) begin
            errors++; $display("FAIL br_granted: state=%0d drive=%b want 3/0", ARB_STATE, BUS_DRIVE_EN);
        end
        M68K_BGACK_n = 1'b0; M68K_BR_n = 1'b1;
        wait_state("br_ext", 3'd4);
        checks++; if (M68K_BG_n !== 1'b1 || EXT_OWNER !== 1'b1 || BUS_DRIVE_EN !== 1'b0) begin
            errors++; $display("FAIL br_ext_outputs: bg=%b ext=%b drive=%b want 1/1/0", M68K_BG_n, EXT_OWNER, BUS_DRIVE_EN);
        end
        M68K_BGACK_n = 1'b1;
        wait_state("br_release", 3'd5);
        checks++; if (EXT_OWNER !== 1'b0 || BUS_DRIVE_EN !== 1'b0) begin
            errors++; $display("FAIL br_release_outputs: ext=%b drive=%b want 0/0", EXT_OWNER, BUS_DRIVE_EN);
        end
        wait_state("br_back_idle", 3'd0);
        checks++; if (BUS_DRIVE_EN !== 1'b1) begin errors++; $display("FAIL br_idle_drive: got %b want 1", BUS_DRIVE_EN); end
        tick(3);
    endtask

    task automatic test_pend_withdraw();
        logic bg_seen = 1'b0;
        M68K_AS_IN_n = 1'b0;   // bus busy: grant must not be issued
        M68K_BR_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (M68K_BG_n === 1'b0) bg_seen = 1'b1;
        end
        checks++; if (ARB_STATE !== 3'd2) begin errors++; $display("FAIL pend_hold: state=%0d want 2", ARB_STATE); end
        M68K_BR_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (M68K_BG_n === 1'b0) bg_seen = 1'b1;
        end
        checks++; if (bg_seen !== 1'b0) begin errors++; $display("FAIL pend_no_bg: bg_seen=%b want 0", bg_seen); end
        checks++; if (ARB_STATE !== 3'd0) begin errors++; $display("FAIL pend_withdraw: state=%0d want 0", ARB_STATE); end
        M68K_AS_IN_n = 1'b1;
        tick(3);
    endtask

    task automatic test_timeout();
        logic idle_seen = 1'b0;
        M68K_BR_n = 1'b0;
        wait_grant("to_grant");
        repeat (15) @(negedge M68K_CLK);
        tick(7);
        checks++; if (M68K_BG_n !== 1'b0 || ARB_STATE !== 3'd3) begin
            errors++; $display("FAIL to_before: bg=%b state=%0d want 0/3 after 15 falls", M68K_BG_n, ARB_STATE);
        end
        @(negedge M68K_CLK);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (ARB_STATE === 3'd0) idle_seen = 1'b1;
        end
        checks++; if (M68K_BG_n !== 1'b1 || BUS_DRIVE_EN !== 1'b1) begin
            errors++; $display("FAIL to_withdraw: bg=%b drive=%b want 1/1 after 16 falls", M68K_BG_n, BUS_DRIVE_EN);
        end
        checks++; if (idle_seen !== 1'b1) begin errors++; $display("FAIL to_idle: idle_seen=%b want 1", idle_seen); end
        M68K_BR_n = 1'b1;
        tick(6);
        checks++; if (ARB_STATE !== 3'd0) begin errors++; $display("FAIL to_final: state=%0d want 0", ARB_STATE); end
    endtask

    task automatic test_fairness();
        logic bg_before_gnt = 1'b0;
        int   n = 0;
        M68K_AS_IN_n = 1'b0;
        M68K_BR_n = 1'b0;
        tick(2);               // BR reaches the FSM together with LOCAL_REQ
        LOCAL_REQ = 1'b1;
        tick(6);
        checks++; if (ARB_STATE !== 3'd2 || LOCAL_GNT !== 1'b0) begin
            errors++; $display("FAIL fair_tie: state=%0d gnt=%b want 2/0", ARB_STATE, LOCAL_GNT);
        end
        M68K_AS_IN_n = 1'b1;
        wait_grant("fair_grant1");
        M68K_BGACK_n = 1'b0;
        wait_state("fair_ext", 3'd4);
        tick(3);
        M68K_BGACK_n = 1'b1;   // BR still low, LOCAL_REQ still high
        while (LOCAL_GNT !== 1'b1 && n < 60) begin
            tick(1); n++;
            if (M68K_BG_n === 1'b0) bg_before_gnt = 1'b1;
        end
        checks++; if (LOCAL_GNT !== 1'b1 || ARB_STATE !== 3'd1) begin
            errors++; $display("FAIL fair_local: gnt=%b state=%0d want 1/1", LOCAL_GNT, ARB_STATE);
        end
        checks++; if (bg_before_gnt !== 1'b0) begin errors++; $display("FAIL fair_order: bg_before_gnt=%b want 0", bg_before_gnt); end
        LOCAL_DONE = 1'b1;
        tick(1);
        LOCAL_DONE = 1'b0;
        tick(2);
        checks++; if (ARB_STATE !== 3'd2 || LOCAL_GNT !== 1'b0) begin
            errors++; $display("FAIL fair_pend_again: state=%0d gnt=%b want 2/0", ARB_STATE, LOCAL_GNT);
        end
        wait_grant("fair_grant2");
        do_reset();
    endtask

    task automatic test_reset_mid_ext();
        M68K_BR_n = 1'b0;
        wait_grant("rst_grant");
        M68K_BGACK_n = 1'b0;
        wait_state("rst_ext", 3'd4);
        checks++; if (EXT_OWNER !== 1'b1) begin errors++; $display("FAIL rst_ext_owner: got %b want 1", EXT_OWNER); end
        #2 RST_n = 1'b0;
        #1;
        checks++; if (M68K_BG_n !== 1'b1 || BUS_DRIVE_EN !== 1'b1 || EXT_OWNER !== 1'b0) begin
            errors++; $display("FAIL rst_async: bg=%b drive=%b ext=%b want 1/1/0", M68K_BG_n, BUS_DRIVE_EN, EXT_OWNER);
        end
        checks++; if (ARB_STATE !== 3'd0 || LOCAL_GNT !== 1'b0) begin
            errors++; $display("FAIL rst_async_state: state=%0d gnt=%b want 0/0", ARB_STATE, LOCAL_GNT);
        end
        tick(1);
        M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1;
        tick(1);
        RST_n = 1'b1;
        tick(4);
        LOCAL_REQ = 1'b1;
        tick(1);
        checks++; if (LOCAL_GNT !== 1'b1) begin errors++; $display("FAIL rst_restart: gnt=%b want 1", LOCAL_GNT); end
        LOCAL_REQ = 1'b0; LOCAL_DONE = 1'b1;
        tick(1);
        LOCAL_DONE = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_local();
        test_br_during_local();
        test_pend_withdraw();
        test_timeout();
        test_fairness();
        test_reset_mid_ext();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
